// File: rtl/cache_fill_fsm.sv
`default_nettype none
// ============================================================================
// Module      : cache_fill_fsm
// Description : Miss-handling controller for a direct-mapped cache.
//               When a miss is seen, it captures the block address and issues
//               eight sequential word reads to main memory. Each returned word
//               is written into the cache data array. On the eighth word the
//               valid+tag entry is also written and the controller returns to
//               IDLE.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_fill_fsm #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  miss_detected,
    input  logic [ADDR_WIDTH-1:0] miss_address,
    input  logic [DATA_WIDTH-1:0] memory_data,
    input  logic                  memory_data_valid,
    output logic                  fsm_busy,
    output logic                  mem_read_en,
    output logic [ADDR_WIDTH-1:0] memory_address,
    output logic                  write_data_array,
    output logic                  write_tag_array,
    output logic [ADDR_WIDTH-1:0] fill_address,
    output logic [2:0]            word_num,
    output logic [DATA_WIDTH-1:0] fill_data
);

    // Controller states
    localparam logic [0:0] c_idle      = 1'b0;
    localparam logic [0:0] c_fill      = 1'b1;

    // A block is eight 16-bit words; the issue counter saturates at 8
    localparam logic [3:0] c_words     = 4'd8;
    localparam logic [2:0] c_last_word = 3'd7;

    logic [0:0]            r_state;
    logic [0:0]            w_next_state;
    logic [ADDR_WIDTH-5:0] r_blk_addr;
    logic [3:0]            r_issue_cnt;
    logic [2:0]            r_recv_cnt;
    logic                  w_issue_active;
    logic                  w_last_return;

    // The byte offset within a block is rebuilt from the counters, so the
    // low nibble of the miss address is intentionally discarded.
    logic                  w_unused_offset;
    assign w_unused_offset = ^miss_address[3:0];

    // Requests remain to be issued while fewer than eight have gone out
    assign w_issue_active = (r_issue_cnt < c_words);

    // The eighth return of the current fill closes the block
    assign w_last_return  = memory_data_valid && (r_recv_cnt == c_last_word);

    // Data to the cache is a straight pass-through of the memory bus
    assign fill_data = memory_data;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Block address capture and issue / receive counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_blk_addr  <= '0;
            r_issue_cnt <= '0;
            r_recv_cnt  <= '0;
        end else if (r_state == c_idle) begin
            if (miss_detected) begin
                r_blk_addr  <= miss_address[ADDR_WIDTH-1:4];
                r_issue_cnt <= '0;
                r_recv_cnt  <= '0;
            end
        end else begin
            // One request per cycle with no backpressure, then hold at 8
            if (w_issue_active) begin
                r_issue_cnt <= r_issue_cnt + 4'd1;
            end
            // Returns arrive in order; the counter wraps 7 -> 0 at completion
            if (memory_data_valid) begin
                r_recv_cnt <= r_recv_cnt + 3'd1;
            end
        end
    end

    // Next-state logic: misses only start a fill from IDLE, and the last
    // returned word ends it
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_idle: begin
                if (miss_detected) begin
                    w_next_state = c_fill;
                end
            end
            c_fill: begin
                if (w_last_return) begin
                    w_next_state = c_idle;
                end
            end
            default: begin
                w_next_state = c_idle;
            end
        endcase
    end

    // Output decode: everything is quiet in IDLE so stale memory returns
    // cannot disturb the cache arrays
    always_comb begin
        fsm_busy         = 1'b0;
        mem_read_en      = 1'b0;
        memory_address   = '0;
        write_data_array = 1'b0;
        write_tag_array  = 1'b0;
        fill_address     = '0;
        word_num         = '0;
        if (r_state == c_fill) begin
            fsm_busy         = 1'b1;
            mem_read_en      = w_issue_active;
            memory_address   = {r_blk_addr, r_issue_cnt[2:0], 1'b0};
            word_num         = r_recv_cnt;
            fill_address     = {r_blk_addr, r_recv_cnt, 1'b0};
            write_data_array = memory_data_valid;
            write_tag_array  = w_last_return;
        end
    end

endmodule
`default_nettype wire
